// File: rtl/period_meter_pkg.sv
// period_meter_pkg: types and constants shared by the period meter files.
package period_meter_pkg;

  // Default width of the measurement counter and result ports.
  localparam int DEFAULT_WIDTH = 16;

  // Number of flops in the sig_in synchronizer chain.
  localparam int SYNC_DEPTH = 2;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

endpackage

// File: rtl/period_meter_sync_edge_det.sv
// sync_edge_det: brings an asynchronous input into the clk domain and
// produces registered one-cycle rise and fall strobes.
// Both strobes see the same pipeline latency, so the distance between any
// two strobes equals the distance between the matching sig_in edges.
module sync_edge_det
  import period_meter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;
  logic [SYNC_DEPTH:0]   fill_q;
  logic                  synced;
  logic                  strobe_ok;

  assign synced    = sync_q[SYNC_DEPTH-1];
  // After reset the chain holds zeros, not real samples; a high input at
  // release would otherwise look like a rise. Strobes stay blocked until
  // both the synchronized sample and the previous sample are genuine.
  assign strobe_ok = fill_q[SYNC_DEPTH];

  // Synchronizer chain, previous-sample register, fill tracker and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      fill_q <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d};
      prev_q <= synced;
      fill_q <= {fill_q[SYNC_DEPTH-1:0], 1'b1};
      rise   <= strobe_ok & synced & ~prev_q;
      fall   <= strobe_ok & ~synced & prev_q;
    end
  end

endmodule

// File: rtl/period_meter.sv
// period_meter: measures the period and high time of a slow clock-like
// input in clk cycles, publishing both values together once per period.
//
// state | meaning
// IDLE  | measurement disabled, waiting for meas_en
// ARM   | enabled, waiting for the first rise to start counting
// HIGH  | counting the high phase, waiting for fall
// LOW   | counting the low phase, waiting for rise to publish
module period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             meas_en,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             meas_valid,
  output logic             overflow
);

  // Counter limit; reaching it without a rise means the input is too slow.
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  // The cycle in which the rise is accepted is the first cycle of the new
  // period, so the counter restarts at one rather than zero. This keeps
  // period=N exact and lets the largest representable period be CNT_MAX.
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_nxt;
  logic [WIDTH-1:0] period_nxt;
  logic [WIDTH-1:0] high_nxt;
  logic             valid_nxt;
  logic             ovf_nxt;
  logic             rise;
  logic             fall;
  logic             at_limit;

  sync_edge_det u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .rise (rise),
    .fall (fall)
  );

  assign at_limit = (cnt == CNT_MAX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath decisions; everything holds unless changed.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    period_nxt = period;
    high_nxt   = high_time;
    valid_nxt  = 1'b0;
    ovf_nxt    = overflow;

    if (!meas_en) begin
      // Disabling aborts any measurement and clears the sticky flag; the
      // last published pair stays visible.
      state_nxt = IDLE;
      ovf_nxt   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = ARM;
        end

        ARM: begin
          // First rise only starts a measurement; nothing to publish yet.
          if (rise) begin
            state_nxt = HIGH;
            cnt_nxt   = CNT_ONE;
          end
        end

        HIGH: begin
          // A rise cannot follow a rise without a fall; ignore it here.
          if (at_limit) begin
            state_nxt = ARM;
            ovf_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
            if (fall) begin
              // High time is parked until the period completes so the two
              // outputs always belong to the same period.
              shadow_nxt = cnt;
              state_nxt  = LOW;
            end
          end
        end

        LOW: begin
          // Rise wins over the limit: a period of exactly CNT_MAX is valid.
          if (rise) begin
            period_nxt = cnt;
            high_nxt   = shadow;
            valid_nxt  = 1'b1;
            cnt_nxt    = CNT_ONE;
            state_nxt  = HIGH;
          end else if (at_limit) begin
            state_nxt = ARM;
            ovf_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Counter, shadow and published result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      shadow     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      shadow     <= shadow_nxt;
      period     <= period_nxt;
      high_time  <= high_nxt;
      meas_valid <= valid_nxt;
      overflow   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed and randomized checks of period_meter against
// an edge-timestamp reference model.
`timescale 1ns/1ps
module tb_period_meter;

  typedef struct {
    int cyc;
    int per;
    int hi;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_in;
  logic        meas_en;
  logic [15:0] period;
  logic [15:0] high_time;
  logic        meas_valid;
  logic        overflow;

  logic        sig8;
  logic        en8;
  logic [7:0]  period8;
  logic [7:0]  high8;
  logic        valid8;
  logic        overflow8;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t obs8_q[$];
  int  r8_q[$];

  bit  model_armed = 1'b0;
  int  last_rise = 0;
  int  last_fall = 0;
  int  last_pub_per = 0;
  int  last_pub_hi = 0;

  period_meter #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .meas_en    (meas_en),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .overflow   (overflow)
  );

  period_meter #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig8),
    .meas_en    (en8),
    .period     (period8),
    .high_time  (high8),
    .meas_valid (valid8),
    .overflow   (overflow8)
  );

  // 4 MHz reference clock.
  always #125 clk = ~clk;

  // Posedge number: after posedge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every published result with the posedge that produced it.
  always @(negedge clk) begin
    if (meas_valid) obs_q.push_back('{cyc, int'(period), int'(high_time)});
    if (valid8) obs8_q.push_back('{cyc, int'(period8), int'(high8)});
  end

  task automatic chk(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  // Drive sig_in to lvl for n clk samples. The model timestamps each edge
  // by the posedge that first samples it: a published pair is expected
  // three edges after the completing rise, reporting the rise-to-rise and
  // rise-to-fall distances of the period just finished.
  task automatic phase(input logic lvl, input int n);
    int k;
    @(negedge clk);
    k = cyc + 1;
    if (lvl && !sig_in) begin
      if (meas_en && !rst) begin
        if (model_armed) begin
          exp_q.push_back('{k + 3, k - last_rise, last_fall - last_rise});
          last_pub_per = k - last_rise;
          last_pub_hi  = last_fall - last_rise;
        end
        model_armed = 1'b1;
      end
      last_rise = k;
    end else if (!lvl && sig_in) begin
      last_fall = k;
    end
    sig_in = lvl;
    repeat (n) @(posedge clk);
  endtask

  task automatic phase8(input logic lvl, input int n);
    @(negedge clk);
    if (lvl && !sig8) r8_q.push_back(cyc + 1);
    sig8 = lvl;
    repeat (n) @(posedge clk);
  endtask

  // Compare every expectation and observation that is already due.
  task automatic compare_due(input string tag);
    int  lim;
    int  n_due;
    int  n_obs;
    ev_t o;
    ev_t e;
    lim   = cyc - 1;
    n_due = 0;
    n_obs = 0;
    foreach (exp_q[i]) if (exp_q[i].cyc <= lim) n_due++;
    foreach (obs_q[i]) if (obs_q[i].cyc <= lim) n_obs++;
    chk({tag, " pulse count"}, n_obs, n_due);
    for (int i = 0; i < n_due && i < n_obs; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, " valid cycle"}, o.cyc, e.cyc);
      chk({tag, " period"}, o.per, e.per);
      chk({tag, " high_time"}, o.hi, e.hi);
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= lim) void'(exp_q.pop_front());
    while (obs_q.size() > 0 && obs_q[0].cyc <= lim) void'(obs_q.pop_front());
  endtask

  initial begin
    rst     = 1'b1;
    sig_in  = 1'b0;
    meas_en = 1'b0;
    sig8    = 1'b0;
    en8     = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #10;
    chk("reset period", int'(period), 0);
    chk("reset high_time", int'(high_time), 0);
    chk("reset meas_valid", int'(meas_valid), 0);
    chk("reset overflow", int'(overflow), 0);
    chk("reset period8", int'(period8), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    meas_en = 1'b1;
    repeat (5) @(posedge clk);

    // Period 128, high 64: first pulse after the second rise.
    for (int i = 0; i < 5; i++) begin
      phase(1'b1, 64);
      phase(1'b0, 64);
    end
    phase(1'b1, 10);
    compare_due("p128");

    // Divider-style period 127, high 64.
    phase(1'b1, 54);
    phase(1'b0, 63);
    for (int i = 0; i < 4; i++) begin
      phase(1'b1, 64);
      phase(1'b0, 63);
    end
    phase(1'b1, 10);
    compare_due("p127");

    // Period change 128 -> 40: no mixed pair.
    phase(1'b1, 54);
    phase(1'b0, 64);
    for (int i = 0; i < 2; i++) begin
      phase(1'b1, 64);
      phase(1'b0, 64);
    end
    for (int i = 0; i < 3; i++) begin
      phase(1'b1, 20);
      phase(1'b0, 20);
    end
    phase(1'b1, 10);
    compare_due("p40");

    // Random phases down to the minimum width.
    phase(1'b0, 30);
    for (int i = 0; i < 10; i++) begin
      phase(1'b1, int'($urandom_range(3, 150)));
      phase(1'b0, int'($urandom_range(3, 150)));
    end
    phase(1'b1, 10);
    compare_due("random");

    // meas_en dropped during the low phase.
    phase(1'b1, 50);
    phase(1'b0, 40);
    phase(1'b1, 60);
    phase(1'b0, 30);
    @(negedge clk);
    meas_en     = 1'b0;
    model_armed = 1'b0;
    repeat (4) @(posedge clk);
    #10;
    chk("en_drop period kept", int'(period), last_pub_per);
    chk("en_drop high_time kept", int'(high_time), last_pub_hi);
    chk("en_drop overflow", int'(overflow), 0);
    phase(1'b0, 10);
    @(negedge clk);
    meas_en = 1'b1;
    phase(1'b0, 20);
    for (int i = 0; i < 3; i++) begin
      phase(1'b1, 60);
      phase(1'b0, 40);
    end
    phase(1'b1, 10);
    compare_due("en_drop");

    // Asynchronous reset in the middle of the high phase.
    phase(1'b1, 20);
    #30;
    rst = 1'b1;
    model_armed  = 1'b0;
    last_pub_per = 0;
    last_pub_hi  = 0;
    #10;
    chk("async rst period", int'(period), 0);
    chk("async rst high_time", int'(high_time), 0);
    chk("async rst meas_valid", int'(meas_valid), 0);
    chk("async rst overflow", int'(overflow), 0);
    repeat (2) @(posedge clk);
    #40;
    rst = 1'b0;
    phase(1'b1, 30);
    chk("post rst period", int'(period), 0);
    phase(1'b0, 50);
    for (int i = 0; i < 3; i++) begin
      phase(1'b1, 50);
      phase(1'b0, 50);
    end
    phase(1'b1, 10);
    compare_due("after rst");
    chk("no overflow at width 16", int'(overflow), 0);

    // Width 8: a period of 255 is the largest that publishes; held low
    // afterwards the counter runs out and overflow is raised.
    @(negedge clk);
    en8 = 1'b1;
    repeat (5) @(posedge clk);
    phase8(1'b1, 128);
    phase8(1'b0, 127);
    phase8(1'b1, 128);
    phase8(1'b0, 127);
    phase8(1'b1, 50);
    phase8(1'b0, 150);
    @(negedge clk);
    chk("w8 pulse count", obs8_q.size(), 2);
    if (obs8_q.size() == 2 && r8_q.size() == 3) begin
      for (int i = 0; i < 2; i++) begin
        chk("w8 valid cycle", obs8_q[i].cyc, r8_q[i + 1] + 3);
        chk("w8 period", obs8_q[i].per, r8_q[i + 1] - r8_q[i]);
        chk("w8 high_time", obs8_q[i].hi, 128);
      end
    end
    chk("w8 overflow before limit", int'(overflow8), 0);
    phase8(1'b0, 100);
    @(negedge clk);
    chk("w8 overflow after limit", int'(overflow8), 1);
    chk("w8 period kept", int'(period8), 255);
    chk("w8 high_time kept", int'(high8), 128);
    chk("w8 no pulse on timeout", obs8_q.size(), 2);
    en8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("w8 overflow cleared", int'(overflow8), 0);
    chk("w8 period after disable", int'(period8), 255);

    phase(1'b1, 10);
    compare_due("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
